lcd_status_writer: RTL and testbench
====================================

Name: lcd_status_writer

Overview:
- Downstream consumer of the front-panel control stage: takes the ADC delay settings (ad1_delay, ad2_delay, ad_valid_delay) and the DIP setting and renders them as a 2x16 text frame.
- Drives the character-buffer write port (lcd_row/lcd_col/lcd_char/lcd_we), then requests a display refresh through the lcd_update/lcd_busy handshake.
- Redraws on any input change, on a force_refresh pulse, or periodically.

Parameters:
- REFRESH_CYCLES, 32'd66000000: idle cycles before an unconditional redraw; 0 disables periodic redraw.
- BUSY_TIMEOUT, 16'd1024: maximum cycles to wait for lcd_busy to rise after lcd_update.

Ports:
- clkcomm  input  1  clock.
- RST  input  1  asynchronous, active-low reset.
- ad1_delay  input  4  delay setting, shown as 1 hex digit.
- ad2_delay  input  4  delay setting, shown as 1 hex digit.
- ad_valid_delay  input  4  delay setting, shown as 1 hex digit.
- DIP  input  8  switch setting, shown as 2 hex digits.
- force_refresh  input  1  single-cycle redraw request.
- lcd_row  output  1  row of the character write.
- lcd_col  output  4  column of the character write.
- lcd_char  output  8  ASCII code of the character write.
- lcd_we  output  1  character write strobe.
- lcd_update  output  1  single-cycle refresh request.
- lcd_busy  input  1  display controller busy.
- frame_count  output  16  number of completed frames, wraps.
- busy_timeout_err  output  1  sticky; set on a busy timeout.

Behaviour:
- Reset: every output 0; snapshot registers 0; dirty=1, so the first frame starts immediately after reset.
- States: IDLE, WRITE, UPDATE, WAIT_RISE, WAIT_FALL.
- IDLE -> WRITE when all of the following hold:
  - (dirty, pending force, or refresh counter == REFRESH_CYCLES-1 with REFRESH_CYCLES != 0)
  - lcd_busy == 0
- On entering WRITE:
  - Snapshot all four inputs.
  - Clear dirty, pending force and refresh counter.
- WRITE:
  - 32 consecutive cycles with lcd_we=1; index 0..31, row = index[4], col = index[3:0].
  - Outputs are registered; the first write appears the cycle after leaving IDLE.
  - All characters come from the snapshot.
- Row 0: "A1:x A2:y AV:z  ", with x at col 3, y at col 8, z at col 13.
- Row 1:
  - "DIP:hh CNT:nnnn " — DIP hi/lo nibbles at cols 4,5; frame_count at cols 11..14, MSB first.
  - Col 15 is a space, except as set by the optional feature.
- Hex digit encoding: 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46 (uppercase).
- UPDATE: lcd_we=0 and lcd_update=1 for exactly one cycle, then WAIT_RISE.
- WAIT_RISE:
  - lcd_busy=1 -> WAIT_FALL.
  - No rise within BUSY_TIMEOUT cycles -> set busy_timeout_err, increment frame_count, go to IDLE.
- WAIT_FALL: lcd_busy=0 -> increment frame_count, go to IDLE. No timeout in this state.
- Change detection:
  - In every state, live inputs != snapshot sets dirty.
  - A change during a frame therefore causes exactly one further frame.
- force_refresh:
  - Latched as pending in any state.
  - Multiple pulses during one frame produce one extra frame.
- Refresh counter counts only in IDLE and saturates at REFRESH_CYCLES-1.
- frame_count wraps at 16'hFFFF -> 0. The displayed value is frame_count at frame start.
- Reset asserted mid-frame: immediate return to IDLE, outputs 0, dirty=1.

Optional Feature:
- Macro LCD_ERR_MARK_EN.
- Defined: row 1 col 15 shows 'E' (8'h45) while busy_timeout_err=1, otherwise space.
- Undefined: col 15 is always space (8'h20); busy_timeout_err still operates.

Test Plan:
- Reset release with ad1=5, ad2=0, adv=7, DIP=8'h80, busy model responding:
  - Exactly 32 lcd_we writes.
  - Row 0 = "A1:5 A2:0 AV:7  ", row 1 = "DIP:80 CNT:0000 ".
  - One lcd_update pulse, then frame_count=1.
- ad1_delay changes 5->6 during write index 10:
  - The current frame still shows '5'.
  - A second frame follows, showing '6' at row 0 col 3.
- Hex encoding: ad2_delay=4'hA, DIP=8'hFF -> chars 8'h41 at row 0 col 8, 8'h46 at row 1 cols 4 and 5.
- lcd_busy held 0 after lcd_update:
  - busy_timeout_err=1 after BUSY_TIMEOUT cycles; frame_count increments.
  - With LCD_ERR_MARK_EN, the next frame has row 1 col 15 = 'E'.
- Three force_refresh pulses during one frame -> exactly one additional frame; lcd_busy high at IDLE delays the WRITE start until it falls.
- REFRESH_CYCLES=100, static inputs -> a new frame starts 100 idle cycles after each completion; RST asserted mid-WRITE -> lcd_we=0 at once and a fresh full frame after release.

Source files
------------

// File: rtl/lcd_status_writer.sv
// Renders the ADC delay settings and the DIP setting as a 2x16 text frame, then requests a display refresh.
// Optional LCD_ERR_MARK_EN: row 1 col 15 shows 'E' while busy_timeout_err is set.
module lcd_status_writer #(
  parameter logic [31:0] REFRESH_CYCLES = 32'd66000000,
  parameter logic [15:0] BUSY_TIMEOUT   = 16'd1024
) (
  input  logic        clkcomm,
  input  logic        RST,
  input  logic [3:0]  ad1_delay,
  input  logic [3:0]  ad2_delay,
  input  logic [3:0]  ad_valid_delay,
  input  logic [7:0]  DIP,
  input  logic        force_refresh,
  output logic        lcd_row,
  output logic [3:0]  lcd_col,
  output logic [7:0]  lcd_char,
  output logic        lcd_we,
  output logic        lcd_update,
  input  logic        lcd_busy,
  output logic [15:0] frame_count,
  output logic        busy_timeout_err
);

  // state      | meaning
  // IDLE       | wait for dirty/force/refresh and lcd_busy low
  // WRITE      | 32 character writes from the snapshot
  // UPDATE     | one-cycle lcd_update request
  // WAIT_RISE  | wait for lcd_busy to rise, bounded by BUSY_TIMEOUT
  // WAIT_FALL  | wait for lcd_busy to fall, frame complete
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_UPDATE,
    ST_WAIT_RISE,
    ST_WAIT_FALL
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  ad1_snap_q, ad1_snap_d;
  logic [3:0]  ad2_snap_q, ad2_snap_d;
  logic [3:0]  adv_snap_q, adv_snap_d;
  logic [7:0]  dip_snap_q, dip_snap_d;
  logic [15:0] cnt_snap_q, cnt_snap_d;
  logic        dirty_q, dirty_d;
  logic        pend_q, pend_d;
  logic [31:0] refresh_cnt_q, refresh_cnt_d;
  logic [15:0] timeout_cnt_q, timeout_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        err_q, err_d;
  logic        lcd_row_q, lcd_row_d;
  logic [3:0]  lcd_col_q, lcd_col_d;
  logic [7:0]  lcd_char_q, lcd_char_d;
  logic        lcd_we_q, lcd_we_d;
  logic        lcd_update_q, lcd_update_d;

  logic        input_changed;
  logic        refresh_hit;
  logic [7:0]  cur_char;
  logic [7:0]  err_mark;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + {4'h0, v};
    else           return 8'h37 + {4'h0, v};
  endfunction

`ifdef LCD_ERR_MARK_EN
  assign err_mark = err_q ? 8'h45 : 8'h20;
`else
  assign err_mark = 8'h20;
`endif

  assign input_changed = ({ad1_delay, ad2_delay, ad_valid_delay, DIP} !=
                          {ad1_snap_q, ad2_snap_q, adv_snap_q, dip_snap_q});
  assign refresh_hit   = (REFRESH_CYCLES != 32'd0) &&
                         (refresh_cnt_q == REFRESH_CYCLES - 32'd1);

  // Row 0 "A1:x A2:y AV:z  ", row 1 "DIP:hh CNT:nnnn " plus the optional mark.
  always_comb begin
    cur_char = 8'h20;
    if (!idx_q[4]) begin
      case (idx_q[3:0])
        4'd0:    cur_char = 8'h41;
        4'd1:    cur_char = 8'h31;
        4'd2:    cur_char = 8'h3A;
        4'd3:    cur_char = hex_char(ad1_snap_q);
        4'd5:    cur_char = 8'h41;
        4'd6:    cur_char = 8'h32;
        4'd7:    cur_char = 8'h3A;
        4'd8:    cur_char = hex_char(ad2_snap_q);
        4'd10:   cur_char = 8'h41;
        4'd11:   cur_char = 8'h56;
        4'd12:   cur_char = 8'h3A;
        4'd13:   cur_char = hex_char(adv_snap_q);
        default: cur_char = 8'h20;
      endcase
    end else begin
      case (idx_q[3:0])
        4'd0:    cur_char = 8'h44;
        4'd1:    cur_char = 8'h49;
        4'd2:    cur_char = 8'h50;
        4'd3:    cur_char = 8'h3A;
        4'd4:    cur_char = hex_char(dip_snap_q[7:4]);
        4'd5:    cur_char = hex_char(dip_snap_q[3:0]);
        4'd7:    cur_char = 8'h43;
        4'd8:    cur_char = 8'h4E;
        4'd9:    cur_char = 8'h54;
        4'd10:   cur_char = 8'h3A;
        4'd11:   cur_char = hex_char(cnt_snap_q[15:12]);
        4'd12:   cur_char = hex_char(cnt_snap_q[11:8]);
        4'd13:   cur_char = hex_char(cnt_snap_q[7:4]);
        4'd14:   cur_char = hex_char(cnt_snap_q[3:0]);
        4'd15:   cur_char = err_mark;
        default: cur_char = 8'h20;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ad1_snap_d    = ad1_snap_q;
    ad2_snap_d    = ad2_snap_q;
    adv_snap_d    = adv_snap_q;
    dip_snap_d    = dip_snap_q;
    cnt_snap_d    = cnt_snap_q;
    dirty_d       = dirty_q | input_changed;
    pend_d        = pend_q | force_refresh;
    refresh_cnt_d = refresh_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    frame_count_d = frame_count_q;
    err_d         = err_q;
    lcd_row_d     = 1'b0;
    lcd_col_d     = 4'd0;
    lcd_char_d    = 8'd0;
    lcd_we_d      = 1'b0;
    lcd_update_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((REFRESH_CYCLES != 32'd0) && !refresh_hit)
          refresh_cnt_d = refresh_cnt_q + 32'd1;
        if ((dirty_d || pend_d || refresh_hit) && !lcd_busy) begin
          state_d       = ST_WRITE;
          idx_d         = 5'd0;
          ad1_snap_d    = ad1_delay;
          ad2_snap_d    = ad2_delay;
          adv_snap_d    = ad_valid_delay;
          dip_snap_d    = DIP;
          cnt_snap_d    = frame_count_q;
          dirty_d       = 1'b0;
          pend_d        = 1'b0;
          refresh_cnt_d = 32'd0;
        end
      end
      ST_WRITE: begin
        lcd_we_d   = 1'b1;
        lcd_row_d  = idx_q[4];
        lcd_col_d  = idx_q[3:0];
        lcd_char_d = cur_char;
        idx_d      = idx_q + 5'd1;
        if (idx_q == 5'd31) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        lcd_update_d  = 1'b1;
        timeout_cnt_d = 16'd0;
        state_d       = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (lcd_busy) begin
          state_d = ST_WAIT_FALL;
        end else if (timeout_cnt_q == BUSY_TIMEOUT - 16'd1) begin
          err_d         = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ST_IDLE;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
      end
      ST_WAIT_FALL: begin
        if (!lcd_busy) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      idx_q         <= 5'd0;
      ad1_snap_q    <= 4'd0;
      ad2_snap_q    <= 4'd0;
      adv_snap_q    <= 4'd0;
      dip_snap_q    <= 8'd0;
      cnt_snap_q    <= 16'd0;
      dirty_q       <= 1'b1;
      pend_q        <= 1'b0;
      refresh_cnt_q <= 32'd0;
      timeout_cnt_q <= 16'd0;
      frame_count_q <= 16'd0;
      err_q         <= 1'b0;
      lcd_row_q     <= 1'b0;
      lcd_col_q     <= 4'd0;
      lcd_char_q    <= 8'd0;
      lcd_we_q      <= 1'b0;
      lcd_update_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ad1_snap_q    <= ad1_snap_d;
      ad2_snap_q    <= ad2_snap_d;
      adv_snap_q    <= adv_snap_d;
      dip_snap_q    <= dip_snap_d;
      cnt_snap_q    <= cnt_snap_d;
      dirty_q       <= dirty_d;
      pend_q        <= pend_d;
      refresh_cnt_q <= refresh_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
      lcd_row_q     <= lcd_row_d;
      lcd_col_q     <= lcd_col_d;
      lcd_char_q    <= lcd_char_d;
      lcd_we_q      <= lcd_we_d;
      lcd_update_q  <= lcd_update_d;
    end
  end

  assign lcd_row          = lcd_row_q;
  assign lcd_col          = lcd_col_q;
  assign lcd_char         = lcd_char_q;
  assign lcd_we           = lcd_we_q;
  assign lcd_update       = lcd_update_q;
  assign frame_count      = frame_count_q;
  assign busy_timeout_err = err_q;

endmodule

// File: tb/tb_lcd_status_writer.sv
// Directed bench for lcd_status_writer: frame contents, redraw triggers, busy handshake and timeout.
module tb_lcd_status_writer;

  logic        clkcomm;
  logic        RST;
  logic [3:0]  ad1_delay, ad2_delay, ad_valid_delay;
  logic [7:0]  DIP;
  logic        force_refresh;
  logic        lcd_row;
  logic [3:0]  lcd_col;
  logic [7:0]  lcd_char;
  logic        lcd_we, lcd_update, lcd_busy;
  logic [15:0] frame_count;
  logic        busy_timeout_err;

  logic        busy_model, busy_hold, busy_auto;
  logic [7:0]  scr [0:31];
  int          we_cnt, upd_cnt;
  int          n_cmp, n_err;

`ifdef LCD_ERR_MARK_EN
  localparam logic [7:0] ERR_MARK = 8'h45;
`else
  localparam logic [7:0] ERR_MARK = 8'h20;
`endif

  assign lcd_busy = busy_model | busy_hold;

  lcd_status_writer #(
    .REFRESH_CYCLES(32'd100),
    .BUSY_TIMEOUT  (16'd1024)
  ) dut (
    .clkcomm         (clkcomm),
    .RST             (RST),
    .ad1_delay       (ad1_delay),
    .ad2_delay       (ad2_delay),
    .ad_valid_delay  (ad_valid_delay),
    .DIP             (DIP),
    .force_refresh   (force_refresh),
    .lcd_row         (lcd_row),
    .lcd_col         (lcd_col),
    .lcd_char        (lcd_char),
    .lcd_we          (lcd_we),
    .lcd_update      (lcd_update),
    .lcd_busy        (lcd_busy),
    .frame_count     (frame_count),
    .busy_timeout_err(busy_timeout_err)
  );

  initial begin
    clkcomm = 1'b0;
    forever #5 clkcomm = ~clkcomm;
  end

  // Character-buffer model: capture every write just after the edge.
  initial begin
    for (int i = 0; i < 32; i++) scr[i] = 8'h00;
    we_cnt  = 0;
    upd_cnt = 0;
    forever begin
      @(posedge clkcomm);
      #1;
      if (lcd_we) begin
        scr[{lcd_row, lcd_col}] = lcd_char;
        we_cnt++;
      end
      if (lcd_update) upd_cnt++;
    end
  end

  // Display controller model: busy for 4 cycles, starting 2 cycles after an update request.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clkcomm);
      if (busy_auto && lcd_update) begin
        repeat (2) @(negedge clkcomm);
        busy_model = 1'b1;
        repeat (4) @(negedge clkcomm);
        busy_model = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row_str(input int r);
    logic [127:0] s;
    for (int c = 0; c < 16; c++) s[127-8*c -: 8] = scr[r*16+c];
    return s;
  endfunction

  task automatic wait_fc(input string tag, input logic [15:0] target, input int budget);
    int n = 0;
    while (frame_count !== target && n < budget) begin
      @(negedge clkcomm);
      n++;
    end
    check_eq(tag, {112'd0, frame_count}, {112'd0, target});
  endtask

  task automatic wait_we(input string tag, input int target, input int budget);
    int n = 0;
    while (we_cnt < target && n < budget) begin
      @(negedge clkcomm);
      n++;
    end
    check_eq(tag, 128'(we_cnt >= target), 128'd1);
  endtask

  task automatic pulse_force;
    @(negedge clkcomm);
    force_refresh = 1'b1;
    @(negedge clkcomm);
    force_refresh = 1'b0;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    RST = 1'b0;
    ad1_delay = 4'h5;
    ad2_delay = 4'h0;
    ad_valid_delay = 4'h7;
    DIP = 8'h80;
    force_refresh = 1'b0;
    busy_hold = 1'b0;
    busy_auto = 1'b1;

    repeat (3) @(negedge clkcomm);
    check_eq("rst_we",     {127'd0, lcd_we}, 128'd0);
    check_eq("rst_update", {127'd0, lcd_update}, 128'd0);
    check_eq("rst_char",   {120'd0, lcd_char}, 128'd0);
    check_eq("rst_fc",     {112'd0, frame_count}, 128'd0);
    check_eq("rst_err",    {127'd0, busy_timeout_err}, 128'd0);

    // First frame straight out of reset.
    RST = 1'b1;
    we_cnt = 0;
    upd_cnt = 0;
    wait_fc("f1_done", 16'd1, 200);
    check_eq("f1_writes", 128'(we_cnt), 128'd32);
    check_eq("f1_updates", 128'(upd_cnt), 128'd1);
    check_eq("f1_row0", row_str(0), "A1:5 A2:0 AV:7  ");
    check_eq("f1_row1", row_str(1), "DIP:80 CNT:0000 ");

    // ad1 changes mid-frame: this frame keeps '5', the next one shows '6'.
    we_cnt = 0;
    pulse_force();
    wait_we("f2_reach_idx10", 10, 100);
    ad1_delay = 4'h6;
    wait_fc("f2_done", 16'd2, 200);
    check_eq("f2_old_digit", {120'd0, scr[3]}, {120'd0, 8'h35});
    we_cnt = 0;
    wait_fc("f3_done", 16'd3, 200);
    check_eq("f3_writes", 128'(we_cnt), 128'd32);
    check_eq("f3_new_digit", {120'd0, scr[3]}, {120'd0, 8'h36});
    check_eq("f3_row1", row_str(1), "DIP:80 CNT:0002 ");

    // Uppercase hex digits.
    we_cnt = 0;
    ad2_delay = 4'hA;
    DIP = 8'hFF;
    wait_fc("f4_done", 16'd4, 200);
    check_eq("hex_ad2", {120'd0, scr[8]}, {120'd0, 8'h41});
    check_eq("hex_dip_hi", {120'd0, scr[20]}, {120'd0, 8'h46});
    check_eq("hex_dip_lo", {120'd0, scr[21]}, {120'd0, 8'h46});
    check_eq("f4_row0", row_str(0), "A1:6 A2:A AV:7  ");
    check_eq("f4_row1", row_str(1), "DIP:FF CNT:0003 ");

    // Three force pulses in one frame give one extra frame, held off while busy is high.
    we_cnt = 0;
    pulse_force();
    wait_we("f5_reach_idx5", 5, 100);
    pulse_force();
    pulse_force();
    pulse_force();
    wait_fc("f5_done", 16'd5, 200);
    busy_hold = 1'b1;
    we_cnt = 0;
    repeat (30) @(negedge clkcomm);
    check_eq("busy_holds_idle", 128'(we_cnt), 128'd0);
    busy_hold = 1'b0;
    wait_fc("f6_done", 16'd6, 200);
    check_eq("f6_writes", 128'(we_cnt), 128'd32);
    repeat (60) @(negedge clkcomm);
    check_eq("no_extra_frame", {112'd0, frame_count}, 128'd6);

    // Periodic redraw: 100 idle cycles, then the first registered write one cycle later.
    wait_fc("f7_refresh_done", 16'd7, 300);
    n = 0;
    while (!lcd_we && n < 300) begin
      @(negedge clkcomm);
      n++;
    end
    check_eq("refresh_gap", 128'(n), 128'd101);
    wait_fc("f8_done", 16'd8, 200);

    // No busy response: timeout after BUSY_TIMEOUT cycles in WAIT_RISE.
    busy_auto = 1'b0;
    pulse_force();
    n = 0;
    while (!lcd_update && n < 100) begin
      @(negedge clkcomm);
      n++;
    end
    check_eq("to_update_seen", {127'd0, lcd_update}, 128'd1);
    check_eq("to_err_before", {127'd0, busy_timeout_err}, 128'd0);
    n = 0;
    while (frame_count === 16'd8 && n < 2000) begin
      @(negedge clkcomm);
      n++;
    end
    check_eq("to_cycles", 128'(n), 128'd1024);
    check_eq("to_err_set", {127'd0, busy_timeout_err}, 128'd1);
    check_eq("to_fc", {112'd0, frame_count}, 128'd9);
    busy_auto = 1'b1;
    we_cnt = 0;
    pulse_force();
    wait_fc("f10_done", 16'd10, 200);
    check_eq("err_mark", {120'd0, scr[31]}, {120'd0, ERR_MARK});
    check_eq("f10_row1", row_str(1), {"DIP:FF CNT:0009", ERR_MARK});
    check_eq("err_sticky", {127'd0, busy_timeout_err}, 128'd1);

    // Reset mid-WRITE, then a complete fresh frame.
    we_cnt = 0;
    pulse_force();
    wait_we("mid_reach_idx8", 8, 100);
    RST = 1'b0;
    #1;
    check_eq("midrst_we", {127'd0, lcd_we}, 128'd0);
    check_eq("midrst_fc", {112'd0, frame_count}, 128'd0);
    check_eq("midrst_err", {127'd0, busy_timeout_err}, 128'd0);
    repeat (2) @(negedge clkcomm);
    RST = 1'b1;
    we_cnt = 0;
    wait_fc("post_rst_done", 16'd1, 200);
    check_eq("post_rst_writes", 128'(we_cnt), 128'd32);
    check_eq("post_rst_row0", row_str(0), "A1:6 A2:A AV:7  ");
    check_eq("post_rst_row1", row_str(1), "DIP:FF CNT:0000 ");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
